// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Optional feature macro: WB_ARB_ZERO_DROP_EN (see wb_write_arbiter.sv).
package wb_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  // Grant encoding doubles as the mux select value and as the bit index in req/gnt.
  localparam logic GRANT_A = 1'b1;
  localparam logic GRANT_B = 1'b0;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Requester handshakes plus register-file write port of the write-back arbiter.
// slave is the arbiter's view; master is the requester/register-file side.
interface wb_write_arbiter_if #(
  parameter int unsigned ADDR_W = wb_write_arbiter_pkg::REG_ADDR_W,
  parameter int unsigned DATA_W = wb_write_arbiter_pkg::REG_DATA_W
);

  logic              hold;
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              ready_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              ready_b;
  logic              mux_sel;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
    output ready_a, ready_b, mux_sel, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  ready_a, ready_b, mux_sel, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot-or-zero grant, req/gnt bit 1 = A, bit 0 = B.
module rr_arb2
  import wb_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[1]) begin
      last_grant_d = GRANT_A;
    end else if (gnt[0]) begin
      last_grant_d = GRANT_B;
    end
  end

  // On contention the requester that did not win last time goes next.
  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      unique case (req)
        2'b10:   gnt = 2'b10;
        2'b01:   gnt = 2'b01;
        2'b11:   gnt = (last_grant_q == GRANT_B) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: round-robin between A and B, registered write port.
// WB_ARB_ZERO_DROP_EN: accepted writes to register 0 leave rf_we low.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input logic                clk,
  input logic                rst_n,
  wb_write_arbiter_if.slave  bus
);

  logic [1:0]        req, gnt;
  logic              arb_hold;
  logic              any_gnt;
  logic              wr_drop;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              mux_sel_q, mux_sel_d;

  assign req = {bus.req_a, bus.req_b};
  // Reset gates grants so ready stays low while rst_n is asserted.
  assign arb_hold = bus.hold | ~rst_n;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (arb_hold),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.ready_a = gnt[1];
  assign bus.ready_b = gnt[0];
  assign any_gnt     = |gnt;

  always_comb begin
    win_addr = gnt[1] ? bus.addr_a : bus.addr_b;
    win_data = gnt[1] ? bus.data_a : bus.data_b;
`ifdef WB_ARB_ZERO_DROP_EN
    wr_drop  = (win_addr == ADDR_W'(ZERO_REG));
`else
    wr_drop  = 1'b0;
`endif
  end

  always_comb begin
    rf_we_d    = any_gnt & ~wr_drop;
    rf_waddr_d = any_gnt ? win_addr : rf_waddr_q;
    rf_wdata_d = any_gnt ? win_data : rf_wdata_q;
    mux_sel_d  = any_gnt ? gnt[1]   : mux_sel_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      mux_sel_q  <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mux_sel_q  <= mux_sel_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.mux_sel  = mux_sel_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter; expected writes are queued when driven.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
  } wr_t;

  logic clk;
  logic rst_n;
  wb_write_arbiter_if bus ();

  wb_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wr_t  exp_q[$];
  wr_t  obs;
  wr_t  exp_w;
  wr_t  m_out;
  logic m_last;
  int   vectors = 0;
  int   miscompares = 0;

  assign obs = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.mux_sel};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle of stimulus, predicts readies and queues the expected write.
  task automatic drive(input logic h, input logic ra, input logic [4:0] aa,
                       input logic [31:0] da, input logic rb, input logic [4:0] ab,
                       input logic [31:0] db, output logic ga, output logic gb);
    bus.hold = h;
    bus.req_a = ra; bus.addr_a = aa; bus.data_a = da;
    bus.req_b = rb; bus.addr_b = ab; bus.data_b = db;
    #1;
    ga = rst_n && !h && ra && (!rb || m_last == GRANT_B);
    gb = rst_n && !h && rb && !ga;
    if (!rst_n) begin
      m_out  = '0;
      m_last = GRANT_B;
    end else if (ga) begin
      m_out  = '{we: 1'b1, addr: aa, data: da, sel: 1'b1};
      m_last = GRANT_A;
    end else if (gb) begin
      m_out  = '{we: 1'b1, addr: ab, data: db, sel: 1'b0};
      m_last = GRANT_B;
    end else begin
      m_out.we = 1'b0;
    end
`ifdef WB_ARB_ZERO_DROP_EN
    if ((ga || gb) && m_out.addr == 5'd0) m_out.we = 1'b0;
`endif
    exp_q.push_back(m_out);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ga, gb;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 5'd9, 32'hAAAA_0000, 1'b1, 5'd4, 32'hBBBB_0000, ga, gb);
      vectors++;
      if ({bus.ready_a, bus.ready_b} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_ready[%0d]: got %b%b want 00", i, bus.ready_a, bus.ready_b);
      end
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w || obs !== wr_t'(0)) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: got we=%b a=%0d d=%h s=%b want all zero",
                 i, obs.we, obs.addr, obs.data, obs.sel);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    logic ga, gb;
    logic ra[2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, ra[i], 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, ga, gb);
      vectors++;
      if ({bus.ready_a, bus.ready_b} !== {ga, gb} || bus.ready_a !== ra[i]) begin
        miscompares++;
        $display("FAIL single_a_ready[%0d]: got %b%b want %b%b", i, bus.ready_a,
                 bus.ready_b, ga, gb);
      end
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("FAIL single_a_write[%0d]: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%b",
                 i, obs.we, obs.addr, obs.data, obs.sel, exp_w.we, exp_w.addr, exp_w.data,
                 exp_w.sel);
      end
    end
  endtask

  task automatic test_contention();
    logic ga, gb;
    logic sel_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, ga, gb);
    tick();
    exp_w = exp_q.pop_front();
    rst_n = 1'b1;
    vectors++;
    if (obs !== exp_w) begin
      miscompares++;
      $display("FAIL contention_reset: got we=%b a=%0d s=%b want all zero",
               obs.we, obs.addr, obs.sel);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, ga, gb);
      vectors++;
      if ({bus.ready_a, bus.ready_b} !== {sel_pat[i], ~sel_pat[i]}) begin
        miscompares++;
        $display("FAIL contention_ready[%0d]: got %b%b want %b%b", i, bus.ready_a,
                 bus.ready_b, sel_pat[i], ~sel_pat[i]);
      end
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w || obs.sel !== sel_pat[i]) begin
        miscompares++;
        $display("FAIL contention_write[%0d]: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%b",
                 i, obs.we, obs.addr, obs.data, obs.sel, exp_w.we, exp_w.addr, exp_w.data,
                 exp_w.sel);
      end
    end
  endtask

  task automatic test_same_dest();
    logic ga, gb;
    logic        ra[2] = '{1'b1, 1'b0};
    logic [31:0] want[2] = '{32'h11, 32'h22};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, ra[i], 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, ga, gb);
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w || obs.we !== 1'b1 || obs.addr !== 5'd7 || obs.data !== want[i]) begin
        miscompares++;
        $display("FAIL same_dest[%0d]: got we=%b a=%0d d=%h s=%b want we=1 a=7 d=%h",
                 i, obs.we, obs.addr, obs.data, obs.sel, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic ga, gb;
    logic h[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic rb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(h[i], 1'b0, 5'd0, 32'h0, rb[i], 5'd5, 32'h55, ga, gb);
      vectors++;
      if ({bus.ready_a, bus.ready_b} !== {ga, gb}) begin
        miscompares++;
        $display("FAIL hold_ready[%0d]: got %b%b want %b%b", i, bus.ready_a, bus.ready_b,
                 ga, gb);
      end
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("FAIL hold_write[%0d]: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%b",
                 i, obs.we, obs.addr, obs.data, obs.sel, exp_w.we, exp_w.addr, exp_w.data,
                 exp_w.sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ga, gb;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b0, 1'b1, 5'(11 + i), 32'hA000 + i, 1'b0, 5'd0, 32'h0, ga, gb);
      else       drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(20 + i), 32'hB000 + i, ga, gb);
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%b",
                 i, obs.we, obs.addr, obs.data, obs.sel, exp_w.we, exp_w.addr, exp_w.data,
                 exp_w.sel);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ga, gb;
    logic rn[3] = '{1'b1, 1'b0, 1'b1};
    logic ra[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      rst_n = rn[i];
      drive(1'b0, ra[i], 5'd10, 32'hA5, 1'b0, 5'd0, 32'h0, ga, gb);
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%b",
                 i, obs.we, obs.addr, obs.data, obs.sel, exp_w.we, exp_w.addr, exp_w.data,
                 exp_w.sel);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_reg();
    logic ga, gb;
    logic rb[2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'hFF, rb[i], 5'd2, 32'h2, ga, gb);
      vectors++;
      // Second cycle is contested: B must win because A was granted last.
      if ({bus.ready_a, bus.ready_b} !== {ga, gb} || bus.ready_a !== (i == 0)) begin
        miscompares++;
        $display("FAIL zero_reg_ready[%0d]: got %b%b want %b%b", i, bus.ready_a, bus.ready_b,
                 ga, gb);
      end
      tick();
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs !== exp_w) begin
        miscompares++;
        $display("FAIL zero_reg_write[%0d]: got we=%b a=%0d d=%h s=%b want we=%b a=%0d d=%h s=%b",
                 i, obs.we, obs.addr, obs.data, obs.sel, exp_w.we, exp_w.addr, exp_w.data,
                 exp_w.sel);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    m_last = GRANT_B;
    m_out  = '0;
    bus.hold = 1'b0;
    bus.req_a = 1'b0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.addr_b = '0; bus.data_b = '0;
    tick();
    test_reset();
    test_single_a();
    test_contention();
    test_same_dest();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
